gshare_predictor: RTL and testbench

//  Parametrised dynamic branch predictor for the IFU fetch stage; successor to the 2-bit bimodal predictor.
//  Per fetched instruction: looks up an N-bit saturating-counter pattern table, indexed bimodally or gshare (PC xor GHR).

---
 rtl/core101_ifu_pkg.sv | 21 ++
 rtl/pred_counter_table.sv | 58 +++++
 rtl/gshare_predictor.sv | 75 +++++++
 tb/tb_gshare_predictor.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core101_ifu_pkg.sv
// core101_ifu_pkg: opcode constants, predictor FSM states and immediate
// extraction shared by the IFU branch-prediction blocks.
package core101_ifu_pkg;

    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    typedef enum logic {
        PRED_CLEAR = 1'b0,
        PRED_READY = 1'b1
    } pred_state_e;

    function automatic logic [31:0] imm_b(input logic [31:0] ins);
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] ins);
        return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/pred_counter_table.sv
// pred_counter_table: saturating-counter pattern table with one async read
// port, one update port and a sequential clear that gates ready_out.
module pred_counter_table
    import core101_ifu_pkg::*;
#(
    parameter int IDX_W = 10,
    parameter int CTR_W = 2
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic             clear_in,
    input  logic [IDX_W-1:0] rd_index_in,
    output logic [CTR_W-1:0] rd_ctr_out,
    input  logic             wr_en_in,
    input  logic [IDX_W-1:0] wr_index_in,
    input  logic             wr_taken_in,
    output logic             ready_out
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;

    pred_state_e      state_q;
    logic [IDX_W-1:0] clr_ptr_q;
    logic [CTR_W-1:0] mem_q [DEPTH];
    logic [CTR_W-1:0] wr_old;
    logic [CTR_W-1:0] wr_new;

    assign rd_ctr_out = mem_q[rd_index_in];
    assign ready_out  = state_q == PRED_READY;
    assign wr_old     = mem_q[wr_index_in];
    assign wr_new     = wr_taken_in ? (wr_old == CTR_MAX ? wr_old : wr_old + 1'b1)
                                    : (wr_old == '0 ? wr_old : wr_old - 1'b1);

    // Storage is left unreset: the clear sweep initialises it before ready_out rises.
    always_ff @(posedge clock_in) begin
        if (state_q == PRED_CLEAR)
            mem_q[clr_ptr_q] <= CTR_INIT;
        else if (wr_en_in)
            mem_q[wr_index_in] <= wr_new;
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q   <= PRED_CLEAR;
            clr_ptr_q <= '0;
        end else if (clear_in) begin
            state_q   <= PRED_CLEAR;
            clr_ptr_q <= '0;
        end else if (state_q == PRED_CLEAR) begin
            clr_ptr_q <= clr_ptr_q + 1'b1;
            if (&clr_ptr_q)
                state_q <= PRED_READY;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: bimodal/gshare direction predictor with B/JAL target
// generation and a speculative global history restored on mispredict.
module gshare_predictor
    import core101_ifu_pkg::*;
#(
    parameter int IDX_W  = 10,
    parameter int CTR_W  = 2,
    parameter int HIST_W = 8,
    parameter int MODE   = 1
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic              clear_in,
    input  logic              fetch_valid_in,
    input  logic [31:0]       ins_data_in,
    input  logic [31:0]       pc_addr_in,
    input  logic              feedback_enable_in,
    input  logic              taken_branch_in,
    input  logic              mispredict_in,
    input  logic [IDX_W-1:0]  fb_index_in,
    input  logic [HIST_W-1:0] fb_ghr_in,
    output logic              taken_pred_out,
    output logic [31:0]       pred_pc_out,
    output logic [IDX_W-1:0]  pred_index_out,
    output logic [HIST_W-1:0] pred_ghr_out,
    output logic              ready_out
);

    logic [HIST_W-1:0] ghr_q, ghr_d;
    logic [IDX_W-1:0]  base_idx;
    logic [CTR_W-1:0]  ctr;
    logic              is_br, is_jal;

    assign base_idx       = pc_addr_in[IDX_W+1:2];
    assign pred_index_out = MODE != 0 ? base_idx ^ IDX_W'(ghr_q) : base_idx;
    assign pred_ghr_out   = ghr_q;
    assign is_br          = fetch_valid_in && ready_out && ins_data_in[6:2] == OPC_BRANCH;
    assign is_jal         = fetch_valid_in && ready_out && ins_data_in[6:2] == OPC_JAL;
    assign taken_pred_out = is_br ? ctr[CTR_W-1] : is_jal;
    assign pred_pc_out    = !taken_pred_out ? '0
                          : is_jal ? pc_addr_in + imm_j(ins_data_in)
                          : pc_addr_in + imm_b(ins_data_in);

    // Shifting via truncating cast keeps HIST_W=1 legal (history becomes the new bit).
    always_comb begin
        ghr_d = clear_in ? '0
              : !ready_out ? ghr_q
              : feedback_enable_in && mispredict_in ? HIST_W'({fb_ghr_in, taken_branch_in})
              : is_br ? HIST_W'({ghr_q, taken_pred_out})
              : ghr_q;
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in)
            ghr_q <= '0;
        else
            ghr_q <= ghr_d;
    end

    pred_counter_table #(
        .IDX_W(IDX_W),
        .CTR_W(CTR_W)
    ) u_table (
        .clock_in    (clock_in),
        .reset_in    (reset_in),
        .clear_in    (clear_in),
        .rd_index_in (pred_index_out),
        .rd_ctr_out  (ctr),
        .wr_en_in    (feedback_enable_in),
        .wr_index_in (fb_index_in),
        .wr_taken_in (taken_branch_in),
        .ready_out   (ready_out)
    );

endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: scenario tasks drive fetch/feedback, a queue holds
// expected predictions until the combinational outputs are sampled.
module tb_gshare_predictor;

    localparam logic [31:0] BEQ16 = 32'h0000_0863;
    localparam logic [31:0] JAL20 = 32'h0200_006F;
    localparam logic [31:0] ADDI  = 32'h0000_0013;

    logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0, fv = 1'b0;
    logic        fb_en = 1'b0, fb_tk = 1'b0, fb_mp = 1'b0;
    logic [31:0] ins = '0, pc = '0;
    logic [9:0]  fb_idx = '0;
    logic [7:0]  fb_ghr = '0;
    logic        taken;
    logic [31:0] pred_pc;
    logic [9:0]  pred_idx;
    logic [7:0]  pred_ghr;
    logic        ready;

    int errors = 0;
    int checks = 0;
    logic [7:0] ghr_m = '0;

    typedef struct {
        logic        taken;
        logic [31:0] tgt;
        logic [9:0]  idx;
        logic [7:0]  ghr;
    } exp_t;
    exp_t sb[$];

    gshare_predictor dut (
        .clock_in           (clk),
        .reset_in           (rst_n),
        .clear_in           (clear),
        .fetch_valid_in     (fv),
        .ins_data_in        (ins),
        .pc_addr_in         (pc),
        .feedback_enable_in (fb_en),
        .taken_branch_in    (fb_tk),
        .mispredict_in      (fb_mp),
        .fb_index_in        (fb_idx),
        .fb_ghr_in          (fb_ghr),
        .taken_pred_out     (taken),
        .pred_pc_out        (pred_pc),
        .pred_index_out     (pred_idx),
        .pred_ghr_out       (pred_ghr),
        .ready_out          (ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pc_for(input logic [9:0] idx);
        logic [9:0] b;
        b = idx ^ {2'b00, ghr_m};
        return {20'h0, b, 2'b00};
    endfunction

    // Drives one fetch at the falling edge and queues the prediction it should produce.
    task automatic drive_fetch(input logic [31:0] i, input logic [31:0] p,
                               input logic t, input logic [31:0] tgt, input logic rdy);
        exp_t e;
        @(negedge clk);
        ins = i; pc = p; fv = 1'b1;
        e.taken = t; e.tgt = tgt; e.idx = p[11:2] ^ {2'b00, ghr_m}; e.ghr = ghr_m;
        sb.push_back(e);
        if (rdy && i[6:2] == 5'b11000) ghr_m = {ghr_m[6:0], t};
    endtask

    task automatic feedback(input logic [9:0] idx, input logic tk, input logic mp, input logic [7:0] g);
        @(negedge clk);
        fv = 1'b0; fb_en = 1'b1; fb_idx = idx; fb_tk = tk; fb_mp = mp; fb_ghr = g;
        if (mp) ghr_m = {g[6:0], tk};
        @(negedge clk);
        fb_en = 1'b0; fb_mp = 1'b0;
    endtask

    task automatic idle;
        @(negedge clk);
        fv = 1'b0;
    endtask

    task automatic test_reset;
        exp_t e;
        int cnt;
        ins = BEQ16; pc = 32'h100; fv = 1'b1;
        e.taken = 1'b0; e.tgt = '0; e.idx = 10'h040; e.ghr = '0;
        sb.push_back(e);
        repeat (2) @(negedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if ({taken, pred_pc, pred_idx, pred_ghr} !== {e.taken, e.tgt, e.idx, e.ghr}) begin
            errors++;
            $display("FAIL reset_outputs: got t=%0b pc=%h idx=%h ghr=%h want t=%0b pc=%h idx=%h ghr=%h",
                     taken, pred_pc, pred_idx, pred_ghr, e.taken, e.tgt, e.idx, e.ghr);
        end
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cnt = 0;
        while (ready !== 1'b1 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
            #1;
            if (cnt == 10) begin
                checks++;
                if (taken !== 1'b0) begin errors++; $display("FAIL clear_branch_taken: got %b want 0", taken); end
            end
        end
        fv = 1'b0;
        checks++;
        if (cnt != 1024) begin errors++; $display("FAIL init_cycles: got %0d want 1024", cnt); end
    endtask

    task automatic test_predict;
        exp_t e;
        drive_fetch(BEQ16, 32'h100, 1'b0, 32'h0, 1'b1);
        #2;
        e = sb.pop_front();
        checks++;
        if ({taken, pred_pc, pred_idx, pred_ghr} !== {e.taken, e.tgt, e.idx, e.ghr}) begin
            errors++;
            $display("FAIL beq_cold: got t=%0b pc=%h idx=%h ghr=%h want t=%0b pc=%h idx=%h ghr=%h",
                     taken, pred_pc, pred_idx, pred_ghr, e.taken, e.tgt, e.idx, e.ghr);
        end
        feedback(10'h040, 1'b1, 1'b0, 8'h00);
        feedback(10'h040, 1'b1, 1'b0, 8'h00);
        drive_fetch(BEQ16, 32'h100, 1'b1, 32'h110, 1'b1);
        #2;
        e = sb.pop_front();
        checks++;
        if ({taken, pred_pc, pred_idx, pred_ghr} !== {e.taken, e.tgt, e.idx, e.ghr}) begin
            errors++;
            $display("FAIL beq_trained: got t=%0b pc=%h idx=%h ghr=%h want t=%0b pc=%h idx=%h ghr=%h",
                     taken, pred_pc, pred_idx, pred_ghr, e.taken, e.tgt, e.idx, e.ghr);
        end
        idle();
    endtask

    task automatic test_saturation;
        exp_t e;
        logic [31:0] p;
        string nm[4] = '{"sat_hi_dec1", "sat_hi_dec2", "sat_lo_floor", "sat_lo_inc2"};
        for (int s = 0; s < 4; s++) begin
            case (s)
                0: begin repeat (5) feedback(10'h040, 1'b1, 1'b0, 8'h00); feedback(10'h040, 1'b0, 1'b0, 8'h00); end
                1: feedback(10'h040, 1'b0, 1'b0, 8'h00);
                2: begin repeat (2) feedback(10'h200, 1'b0, 1'b0, 8'h00); feedback(10'h200, 1'b1, 1'b0, 8'h00); end
                default: feedback(10'h200, 1'b1, 1'b0, 8'h00);
            endcase
            p = pc_for(s < 2 ? 10'h040 : 10'h200);
            drive_fetch(BEQ16, p, s == 0 || s == 3, (s == 0 || s == 3) ? p + 32'd16 : 32'h0, 1'b1);
            #2;
            e = sb.pop_front();
            checks++;
            if ({taken, pred_pc, pred_idx, pred_ghr} !== {e.taken, e.tgt, e.idx, e.ghr}) begin
                errors++;
                $display("FAIL %s: got t=%0b pc=%h idx=%h ghr=%h want t=%0b pc=%h idx=%h ghr=%h",
                         nm[s], taken, pred_pc, pred_idx, pred_ghr, e.taken, e.tgt, e.idx, e.ghr);
            end
        end
        idle();
    endtask

    task automatic test_jal;
        exp_t e;
        string nm[3] = '{"jal_wrap", "jal_no_write", "non_branch"};
        for (int s = 0; s < 3; s++) begin
            case (s)
                0: drive_fetch(JAL20, 32'hFFFF_FFF0, 1'b1, 32'h0000_0010, 1'b1);
                1: drive_fetch(BEQ16, 32'hFFFF_FFF0, 1'b0, 32'h0, 1'b1);
                default: drive_fetch(ADDI, 32'h0000_0040, 1'b0, 32'h0, 1'b1);
            endcase
            #2;
            e = sb.pop_front();
            checks++;
            if ({taken, pred_pc, pred_idx, pred_ghr} !== {e.taken, e.tgt, e.idx, e.ghr}) begin
                errors++;
                $display("FAIL %s: got t=%0b pc=%h idx=%h ghr=%h want t=%0b pc=%h idx=%h ghr=%h",
                         nm[s], taken, pred_pc, pred_idx, pred_ghr, e.taken, e.tgt, e.idx, e.ghr);
            end
            if (s == 0) begin
                idle();
                #1;
                checks++;
                if (pred_ghr !== ghr_m) begin errors++; $display("FAIL jal_ghr: got %h want %h", pred_ghr, ghr_m); end
            end
        end
        idle();
    endtask

    task automatic test_clear;
        exp_t e;
        int cnt;
        int bad;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        ghr_m = '0;
        #1;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL clear_ready_drop: got %b want 0", ready); end
        checks++;
        if (pred_ghr !== 8'h00) begin errors++; $display("FAIL clear_ghr: got %h want 00", pred_ghr); end
        cnt = 0;
        while (ready !== 1'b1 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
            fb_en = (cnt == 3); fb_tk = 1'b1; fb_mp = 1'b1; fb_idx = 10'h000; fb_ghr = 8'hFF;
            #1;
            if (cnt == 5) begin
                checks++;
                if (pred_ghr !== 8'h00) begin errors++; $display("FAIL clear_fb_ghr: got %h want 00", pred_ghr); end
            end
        end
        fb_en = 1'b0; fb_mp = 1'b0;
        checks++;
        if (cnt != 1024) begin errors++; $display("FAIL clear_cycles: got %0d want 1024", cnt); end
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            drive_fetch(BEQ16, 32'(i) << 2, 1'b0, 32'h0, 1'b1);
            #2;
            e = sb.pop_front();
            checks++;
            if ({taken, pred_pc, pred_idx, pred_ghr} !== {e.taken, e.tgt, e.idx, e.ghr}) begin
                errors++;
                if (bad++ < 8)
                    $display("FAIL sweep[%0d]: got t=%0b pc=%h idx=%h ghr=%h want t=%0b pc=%h idx=%h ghr=%h",
                             i, taken, pred_pc, pred_idx, pred_ghr, e.taken, e.tgt, e.idx, e.ghr);
            end
        end
        idle();
    endtask

    task automatic test_ghr;
        exp_t e;
        for (int s = 0; s < 4; s++) begin
            if (s < 3) begin
                drive_fetch(BEQ16, 32'h200 + 32'(4 * s), 1'b0, 32'h0, 1'b1);
            end else begin
                drive_fetch(BEQ16, 32'h300, 1'b0, 32'h0, 1'b1);
                fb_en = 1'b1; fb_mp = 1'b1; fb_tk = 1'b1; fb_ghr = 8'h5A; fb_idx = 10'h3FE;
                ghr_m = 8'hB5;
            end
            #2;
            e = sb.pop_front();
            checks++;
            if ({taken, pred_pc, pred_idx, pred_ghr} !== {e.taken, e.tgt, e.idx, e.ghr}) begin
                errors++;
                $display("FAIL ghr_fetch%0d: got t=%0b pc=%h idx=%h ghr=%h want t=%0b pc=%h idx=%h ghr=%h",
                         s, taken, pred_pc, pred_idx, pred_ghr, e.taken, e.tgt, e.idx, e.ghr);
            end
        end
        @(negedge clk);
        fv = 1'b0; fb_en = 1'b0; fb_mp = 1'b0;
        #1;
        checks++;
        if (pred_ghr !== 8'hB5) begin errors++; $display("FAIL ghr_restore: got %h want b5", pred_ghr); end
        @(negedge clk);
        fb_en = 1'b0; fb_mp = 1'b1; fb_ghr = 8'h00;
        @(negedge clk);
        fb_en = 1'b1; fb_mp = 1'b0; fb_tk = 1'b1; fb_idx = 10'h3FF;
        @(negedge clk);
        fb_en = 1'b0;
        #1;
        checks++;
        if (pred_ghr !== 8'hB5) begin errors++; $display("FAIL ghr_unqualified: got %h want b5", pred_ghr); end
    endtask

    task automatic test_reset_mid_clear;
        int cnt;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL midclear_ready: got %b want 0", ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cnt = 0;
        while (ready !== 1'b1 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
            #1;
        end
        checks++;
        if (cnt != 1024) begin errors++; $display("FAIL midclear_cycles: got %0d want 1024", cnt); end
    endtask

    initial begin
        test_reset();
        test_predict();
        test_saturation();
        test_jal();
        test_clear();
        test_ghr();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
